rs_operand_sel: RTL and testbench

- Parametrised, pipelined successor to the single-source rs3 select mux.
- Selects one register-source address from NUM_SRC candidate sources using an encoded select. Registers the result behind a valid/ready handshake with a 2-entry skid buffer.
- Illegal or disabled selects hold the last good address, matching legacy hold semantics, and are flagged and counted.
- Sits between the decode/control unit and the register-file read port for any rsN operand.

---
 rtl/rs_operand_sel.sv | 159 +++++++++++++++
 tb/tb_rs_operand_sel.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rs_operand_sel.sv
// rs_operand_sel: picks one register-source address from NUM_SRC candidates by
// an encoded select. The result is registered behind a valid/ready handshake
// with a two-entry buffer (output register plus one skid register).
// An illegal or disabled select re-issues the last good address, flags it as
// held, pulses sel_err and bumps a saturating error counter.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   upstream handshake (in_ready = !skid_valid && !rst)
//   src_addr              packed candidates, source i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   src_en                per-source enable; a disabled source is illegal to select
//   sel                   encoded source select
//   out_valid / out_ready downstream handshake
//   rs_addr, rs_src       selected address and the select code that produced it
//   rs_held               rs_addr is a held value
//   sel_err               one-cycle pulse per accepted illegal select
//   err_count             saturating count of illegal selects
module rs_operand_sel #(
    parameter int unsigned           ADDR_WIDTH   = 5,
    parameter int unsigned           NUM_SRC      = 4,
    parameter int unsigned           SEL_WIDTH    = 2,
    parameter logic [ADDR_WIDTH-1:0] DEFAULT_ADDR = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0] src_addr,
    input  logic [NUM_SRC-1:0]            src_en,
    input  logic [SEL_WIDTH-1:0]          sel,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_WIDTH-1:0]         rs_addr,
    output logic [SEL_WIDTH-1:0]          rs_src,
    output logic                          rs_held,
    output logic                          sel_err,
    output logic [7:0]                    err_count
);

    localparam int unsigned CNT_WIDTH = 8;

    logic                  out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0] out_addr_q,  out_addr_d;
    logic [SEL_WIDTH-1:0]  out_src_q,   out_src_d;
    logic                  out_held_q,  out_held_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [ADDR_WIDTH-1:0] skid_addr_q,  skid_addr_d;
    logic [SEL_WIDTH-1:0]  skid_src_q,   skid_src_d;
    logic                  skid_held_q,  skid_held_d;
    logic [ADDR_WIDTH-1:0] last_good_q,  last_good_d;
    logic                  sel_err_q,    sel_err_d;
    logic [CNT_WIDTH-1:0]  err_count_q,  err_count_d;

    logic                  accept;
    logic                  sel_legal;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [ADDR_WIDTH-1:0] new_addr;

    assign in_ready = !skid_valid_q && !rst;
    assign accept   = in_valid && in_ready;

    // Candidate lookup; codes at or above NUM_SRC match no source and stay illegal.
    always_comb begin
        sel_addr  = '0;
        sel_legal = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (sel == SEL_WIDTH'(i)) begin
                sel_addr  = src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_legal = src_en[i];
            end
        end
    end

    assign new_addr = sel_legal ? sel_addr : last_good_q;

    // Next-state: resolution, error bookkeeping and output/skid movement.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_addr_d   = out_addr_q;
        out_src_d    = out_src_q;
        out_held_d   = out_held_q;
        skid_valid_d = skid_valid_q;
        skid_addr_d  = skid_addr_q;
        skid_src_d   = skid_src_q;
        skid_held_d  = skid_held_q;
        last_good_d  = last_good_q;
        sel_err_d    = 1'b0;
        err_count_d  = err_count_q;

        if (accept) begin
            if (sel_legal) begin
                last_good_d = sel_addr;
            end else begin
                sel_err_d = 1'b1;
                if (err_count_q != {CNT_WIDTH{1'b1}}) begin
                    err_count_d = err_count_q + CNT_WIDTH'(1);
                end
            end
            // Skid is guaranteed empty here because in_ready gated the accept.
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_addr_d  = new_addr;
                out_src_d   = sel;
                out_held_d  = !sel_legal;
            end else begin
                skid_valid_d = 1'b1;
                skid_addr_d  = new_addr;
                skid_src_d   = sel;
                skid_held_d  = !sel_legal;
            end
        end else if (out_valid_q && out_ready) begin
            if (skid_valid_q) begin
                out_addr_d   = skid_addr_q;
                out_src_d    = skid_src_q;
                out_held_d   = skid_held_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_addr_q   <= DEFAULT_ADDR;
            out_src_q    <= '0;
            out_held_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_addr_q  <= DEFAULT_ADDR;
            skid_src_q   <= '0;
            skid_held_q  <= 1'b0;
            last_good_q  <= DEFAULT_ADDR;
            sel_err_q    <= 1'b0;
            err_count_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
            out_src_q    <= out_src_d;
            out_held_q   <= out_held_d;
            skid_valid_q <= skid_valid_d;
            skid_addr_q  <= skid_addr_d;
            skid_src_q   <= skid_src_d;
            skid_held_q  <= skid_held_d;
            last_good_q  <= last_good_d;
            sel_err_q    <= sel_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign rs_addr   = out_addr_q;
    assign rs_src    = out_src_q;
    assign rs_held   = out_held_q;
    assign sel_err   = sel_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_rs_operand_sel.sv
// Directed self-checking bench for rs_operand_sel with default parameters.
// Candidates: source0=9, source1=3, source2=12, source3=7.
module tb_rs_operand_sel;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] src_addr;
    logic [3:0]  src_en;
    logic [1:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  rs_addr;
    logic [1:0]  rs_src;
    logic        rs_held;
    logic        sel_err;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    rs_operand_sel dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src_addr  (src_addr),
        .src_en    (src_en),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rs_addr   (rs_addr),
        .rs_src    (rs_src),
        .rs_held   (rs_held),
        .sel_err   (sel_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [4:0] a, input logic [1:0] s,
                           input logic h);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_addr"},  32'(rs_addr),   32'(a));
        chk({tag, "_src"},   32'(rs_src),    32'(s));
        chk({tag, "_held"},  32'(rs_held),   32'(h));
    endtask

    int exp_cnt;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        src_addr  = {5'd7, 5'd12, 5'd3, 5'd9};
        src_en    = 4'hF;
        sel       = 2'd0;

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rs_addr",   32'(rs_addr),   32'd0);
        chk("rst_rs_src",    32'(rs_src),    32'd0);
        chk("rst_rs_held",   32'(rs_held),   32'd0);
        chk("rst_sel_err",   32'(sel_err),   32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Basic select
        in_valid = 1'b1;
        sel      = 2'd2;
        tick();
        chk_out("basic", 5'd12, 2'd2, 1'b0);
        chk("basic_sel_err", 32'(sel_err), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("basic_drain", 32'(out_valid), 32'd0);

        // Illegal select holds last good address
        in_valid = 1'b1;
        sel      = 2'd1;
        tick();
        chk_out("legal1", 5'd3, 2'd1, 1'b0);
        src_en = 4'b1011;
        sel    = 2'd2;
        tick();
        chk_out("hold", 5'd3, 2'd2, 1'b1);
        chk("hold_sel_err",   32'(sel_err),   32'd1);
        chk("hold_err_count", 32'(err_count), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("hold_sel_err_clr", 32'(sel_err),   32'd0);
        chk("hold_err_keep",    32'(err_count), 32'd1);
        chk("hold_drain",       32'(out_valid), 32'd0);

        // Backpressure through the skid register
        src_en    = 4'hF;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd0;
        tick();
        chk_out("bp_first", 5'd9, 2'd0, 1'b0);
        chk("bp_ready1", 32'(in_ready), 32'd1);
        sel = 2'd1;
        tick();
        chk_out("bp_stall1", 5'd9, 2'd0, 1'b0);
        chk("bp_ready2", 32'(in_ready), 32'd0);
        sel = 2'd2;
        tick();
        chk_out("bp_stall2", 5'd9, 2'd0, 1'b0);
        chk("bp_ready3", 32'(in_ready), 32'd0);
        tick();
        chk_out("bp_stall3", 5'd9, 2'd0, 1'b0);
        out_ready = 1'b1;
        tick();
        chk_out("bp_second", 5'd3, 2'd1, 1'b0);
        chk("bp_ready4", 32'(in_ready), 32'd1);
        tick();
        chk_out("bp_third", 5'd12, 2'd2, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("bp_drain", 32'(out_valid), 32'd0);

        // Saturation: 300 illegal selects; last good address is now 12
        src_en   = 4'b0111;
        sel      = 2'd3;
        in_valid = 1'b1;
        exp_cnt  = 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (exp_cnt < 255) exp_cnt++;
            chk("sat_sel_err",   32'(sel_err),   32'd1);
            chk("sat_err_count", 32'(err_count), 32'(exp_cnt));
        end
        chk_out("sat_hold", 5'd12, 2'd3, 1'b1);
        in_valid = 1'b0;
        tick();
        chk("sat_sel_err_clr", 32'(sel_err),   32'd0);
        chk("sat_final",       32'(err_count), 32'd255);

        // Reset with the skid register full
        src_en    = 4'hF;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd0;
        tick();
        sel = 2'd1;
        tick();
        chk("mid_out_valid", 32'(out_valid), 32'd1);
        chk("mid_in_ready",  32'(in_ready),  32'd0);
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_rs_addr",   32'(rs_addr),   32'd0);
        chk("mrst_err_count", 32'(err_count), 32'd0);
        chk("mrst_in_ready",  32'(in_ready),  32'd1);
        out_ready = 1'b1;
        src_en    = 4'b1110;
        sel       = 2'd0;
        in_valid  = 1'b1;
        tick();
        chk_out("mrst_hold", 5'd0, 2'd0, 1'b1);
        chk("mrst_sel_err",  32'(sel_err),   32'd1);
        chk("mrst_err_cnt1", 32'(err_count), 32'd1);

        // Throughput: one per cycle
        src_en = 4'hF;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            tick();
            case (i)
                0: chk_out("tp0", 5'd9,  2'd0, 1'b0);
                1: chk_out("tp1", 5'd3,  2'd1, 1'b0);
                2: chk_out("tp2", 5'd12, 2'd2, 1'b0);
                default: chk_out("tp3", 5'd7, 2'd3, 1'b0);
            endcase
            chk("tp_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("tp_drain", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
